// File: rtl/taillight_pkg.sv
// Shared types and lamp constants for the sequential taillight controller.
package taillight_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } mode_t;

  // Lamp patterns are written {inner, middle, outer}.
  localparam logic [2:0] PAT0        = 3'b000;
  localparam logic [2:0] PAT1        = 3'b100;
  localparam logic [2:0] PAT2        = 3'b110;
  localparam logic [2:0] PAT3        = 3'b111;
  localparam logic [2:0] LAMP_OFF    = 3'b000;
  localparam logic [2:0] LAMP_ALL_ON = 3'b111;

  function automatic logic [2:0] step_pattern(input logic [1:0] step);
    logic [2:0] pat;
    case (step)
      2'd0:    pat = PAT0;
      2'd1:    pat = PAT1;
      2'd2:    pat = PAT2;
      default: pat = PAT3;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/blink_tick_gen.sv
// Step-rate prescaler: one-cycle tick every DIV clocks, restartable via clear.
module blink_tick_gen #(
  parameter int DIV = 4
) (
  input  logic in_clock,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  always_ff @(posedge in_clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (clear || (div_cnt == LAST)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  assign tick = (div_cnt == LAST);

endmodule

// File: rtl/taillight_sequencer.sv
// Sequential taillight controller for both rear clusters (turn, hazard, optional brake).
// Optional feature: define TAILLIGHT_BRAKE_EN to make brake light the non-sequencing sides.
module taillight_sequencer #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int STEP_HZ = 4
) (
  input  logic in_clock,
  input  logic reset_n,
  input  logic turn_left,
  input  logic turn_right,
  input  logic hazard,
  input  logic brake,
  output logic L_A,
  output logic L_B,
  output logic L_C,
  output logic R_A,
  output logic R_B,
  output logic R_C
);

  import taillight_pkg::*;

  localparam int DIV = CLK_HZ / STEP_HZ;

  // Stage p0/p1: two-flop synchronizers on the switch inputs
  logic turn_left_p0, turn_left_p1;
  logic turn_right_p0, turn_right_p1;
  logic hazard_p0, hazard_p1;
  logic brake_s;

  always_ff @(posedge in_clock or negedge reset_n) begin
    if (!reset_n) begin
      turn_left_p0  <= 1'b0;
      turn_left_p1  <= 1'b0;
      turn_right_p0 <= 1'b0;
      turn_right_p1 <= 1'b0;
      hazard_p0     <= 1'b0;
      hazard_p1     <= 1'b0;
    end else begin
      turn_left_p0  <= turn_left;
      turn_left_p1  <= turn_left_p0;
      turn_right_p0 <= turn_right;
      turn_right_p1 <= turn_right_p0;
      hazard_p0     <= hazard;
      hazard_p1     <= hazard_p0;
    end
  end

`ifdef TAILLIGHT_BRAKE_EN
  logic brake_p0, brake_p1;

  always_ff @(posedge in_clock or negedge reset_n) begin
    if (!reset_n) begin
      brake_p0 <= 1'b0;
      brake_p1 <= 1'b0;
    end else begin
      brake_p0 <= brake;
      brake_p1 <= brake_p0;
    end
  end

  assign brake_s = brake_p1;
`else
  logic brake_unused;
  assign brake_unused = brake;
  assign brake_s      = 1'b0;
`endif

  // Mode FSM
  mode_t state, next_state;

  always_ff @(posedge in_clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = IDLE;
    if (hazard_p1 || (turn_left_p1 && turn_right_p1)) begin
      next_state = HAZARD;
    end else if (turn_left_p1) begin
      next_state = LEFT;
    end else if (turn_right_p1) begin
      next_state = RIGHT;
    end
  end

  // A mode change restarts both the prescaler and the step; it outranks a coincident tick.
  logic clear;
  logic tick;

  assign clear = (next_state != state);

  blink_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .in_clock (in_clock),
    .reset_n  (reset_n),
    .clear    (clear),
    .tick     (tick)
  );

  logic [1:0] step, step_d;

  always_comb begin
    step_d = step;
    if (clear || (next_state == IDLE)) begin
      step_d = 2'd0;
    end else if (tick) begin
      step_d = step + 2'd1;
    end
  end

  always_ff @(posedge in_clock or negedge reset_n) begin
    if (!reset_n) begin
      step <= 2'd0;
    end else begin
      step <= step_d;
    end
  end

  // Lamp decode works on the next state/step so the lamp register updates together with them.
  logic [2:0] pat_d;
  logic [2:0] left_d, right_d;

  always_comb begin
    pat_d   = step_pattern(step_d);
    left_d  = LAMP_OFF;
    right_d = LAMP_OFF;
    case (next_state)
      LEFT: begin
        left_d = pat_d;
        if (brake_s) right_d = LAMP_ALL_ON;
      end
      RIGHT: begin
        right_d = pat_d;
        if (brake_s) left_d = LAMP_ALL_ON;
      end
      HAZARD: begin
        left_d  = pat_d;
        right_d = pat_d;
      end
      default: begin
        if (brake_s) begin
          left_d  = LAMP_ALL_ON;
          right_d = LAMP_ALL_ON;
        end
      end
    endcase
  end

  // Output register
  logic [2:0] left_q, right_q;

  always_ff @(posedge in_clock or negedge reset_n) begin
    if (!reset_n) begin
      left_q  <= LAMP_OFF;
      right_q <= LAMP_OFF;
    end else begin
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign L_A = left_q[2];
  assign L_B = left_q[1];
  assign L_C = left_q[0];
  assign R_A = right_q[2];
  assign R_B = right_q[1];
  assign R_C = right_q[0];

endmodule

// File: tb/tb_taillight_sequencer.sv
// Scoreboard bench for taillight_sequencer at DIV=4 (CLK_HZ=8, STEP_HZ=2).
`timescale 1ns/1ps
module tb_taillight_sequencer;

  logic in_clock   = 1'b0;
  logic reset_n    = 1'b1;
  logic turn_left  = 1'b0;
  logic turn_right = 1'b0;
  logic hazard     = 1'b0;
  logic brake      = 1'b0;
  logic L_A, L_B, L_C, R_A, R_B, R_C;

  taillight_sequencer #(
    .CLK_HZ  (8),
    .STEP_HZ (2)
  ) dut (
    .in_clock   (in_clock),
    .reset_n    (reset_n),
    .turn_left  (turn_left),
    .turn_right (turn_right),
    .hazard     (hazard),
    .brake      (brake),
    .L_A        (L_A),
    .L_B        (L_B),
    .L_C        (L_C),
    .R_A        (R_A),
    .R_B        (R_B),
    .R_C        (R_C)
  );

  always #5 in_clock = ~in_clock;

`ifdef TAILLIGHT_BRAKE_EN
  localparam logic [2:0] BR = 3'b111;
`else
  localparam logic [2:0] BR = 3'b000;
`endif
  localparam logic [5:0] ALL = 6'b111111;
  localparam logic [5:0] RMSK = 6'b000111;

  int cyc = 0;
  always @(posedge in_clock) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [5:0] exp;
    logic [5:0] mask;
    string      name;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  logic [5:0] lamps;
  assign lamps = {L_A, L_B, L_C, R_A, R_B, R_C};

  function automatic logic [2:0] pat(input int s);
    case (s % 4)
      0:       return 3'b000;
      1:       return 3'b100;
      2:       return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  task automatic push(input int at, input logic [5:0] e, input logic [5:0] m, input string nm);
    exp_t x;
    x.at   = at;
    x.exp  = e;
    x.mask = m;
    x.name = nm;
    sb.push_back(x);
  endtask

  task automatic til(input int c);
    while (cyc < c) @(negedge in_clock);
  endtask

  // Monitor: compares every scheduled slot when its cycle comes up.
  always @(negedge in_clock) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t x;
      x = sb.pop_front();
      n_vec++;
      if (x.at < cyc) begin
        n_err++;
        $display("FAIL %s cyc %0d: slot skipped (now cyc %0d)", x.name, x.at, cyc);
      end else if ((lamps & x.mask) !== (x.exp & x.mask)) begin
        n_err++;
        $display("FAIL %s cyc %0d: lamps LLLRRR=%b required %b (mask %b)",
                 x.name, x.at, lamps, x.exp, x.mask);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, k3, k4, m, r, b, c;

    // Reset held with left switch on: everything dark.
    turn_left = 1'b1;
    #1 reset_n = 1'b0;
    for (int i = 1; i <= 3; i++) push(i, 6'b000000, ALL, "reset_hold");
    til(4);

    // Release: LEFT entered 3 cycles later, steps every 4 cycles.
    k = cyc;
    reset_n = 1'b1;
    for (int i = 1; i <= 22; i++)
      push(k + i, (i < 3) ? 6'b000000 : {pat((i - 3) / 4), 3'b000}, ALL, "left_seq");
    til(k + 22);

    // Switch to RIGHT; drop it during step2.
    k2 = cyc;
    turn_left  = 1'b0;
    turn_right = 1'b1;
    for (int i = 23; i <= 24; i++) push(k + i, {pat((i - 3) / 4), 3'b000}, ALL, "left_tail");
    for (int j = 3; j <= 12; j++) push(k2 + j, {3'b000, pat((j - 3) / 4)}, ALL, "right_seq");
    til(k2 + 12);
    turn_right = 1'b0;
    push(k2 + 13, 6'b000110, ALL, "right_drop");
    push(k2 + 14, 6'b000110, ALL, "right_drop");
    for (int j = 15; j <= 18; j++) push(k2 + j, 6'b000000, ALL, "idle_off");
    til(k2 + 18);

    // Both turns -> HAZARD, sides in lockstep for 16 cycles.
    k3 = cyc;
    turn_left  = 1'b1;
    turn_right = 1'b1;
    push(k3 + 1, 6'b000000, ALL, "haz_lat");
    push(k3 + 2, 6'b000000, ALL, "haz_lat");
    for (int j = 3; j <= 18; j++)
      push(k3 + j, {pat((j - 3) / 4), pat((j - 3) / 4)}, ALL, "hazard_seq");
    til(k3 + 18);

    // Back to LEFT, then hazard lands on the step3 tick cycle.
    k4 = cyc;
    turn_right = 1'b0;
    push(k4 + 1, 6'b000000, ALL, "haz_wrap");
    push(k4 + 2, 6'b000000, ALL, "haz_wrap");
    for (int i = 3; i <= 16; i++) push(k4 + i, {pat((i - 3) / 4), 3'b000}, ALL, "left_seq2");
    til(k4 + 16);
    hazard = 1'b1;
    push(k4 + 17, 6'b111000, ALL, "left_step3");
    push(k4 + 18, 6'b111000, ALL, "left_step3");
    for (int i = 19; i <= 22; i++) push(k4 + i, 6'b000000, ALL, "haz_on_tick");
    for (int i = 23; i <= 26; i++) push(k4 + i, 6'b100100, ALL, "haz_step1");
    til(k4 + 26);

    // HAZARD -> RIGHT, then LEFT landing on the step1 tick must restart at step0.
    m = cyc;
    hazard     = 1'b0;
    turn_left  = 1'b0;
    turn_right = 1'b1;
    push(m + 1, 6'b110110, ALL, "haz_step2");
    push(m + 2, 6'b110110, ALL, "haz_step2");
    r = m + 3;
    for (int i = 0; i <= 3; i++) push(r + i, 6'b000000, ALL, "right_step0");
    for (int i = 4; i <= 7; i++) push(r + i, 6'b000100, ALL, "right_step1");
    til(r + 5);
    turn_right = 1'b0;
    turn_left  = 1'b1;
    for (int i = 8; i <= 11; i++) push(r + i, 6'b000000, ALL, "chg_on_tick");
    for (int i = 12; i <= 15; i++) push(r + i, 6'b100000, ALL, "left_step1");
    push(r + 16, 6'b110000, ALL, "left_step2");
    til(r + 16);

    // One-cycle async reset in step2: dark at once, restart from step0.
    for (int i = 17; i <= 24; i++) push(r + i, 6'b000000, ALL, "mid_reset");
    for (int i = 25; i <= 28; i++) push(r + i, 6'b100000, ALL, "restart_s1");
    push(r + 29, 6'b110000, ALL, "restart_s2");
    @(posedge in_clock);
    #2 reset_n = 1'b0;
    @(posedge in_clock);
    #2 reset_n = 1'b1;
    til(r + 29);

    // Brake while LEFT sequences: right side steady (only with the brake build).
    b = cyc;
    brake = 1'b1;
    push(b + 1, 6'b000000, RMSK, "brake_lat");
    push(b + 2, 6'b000000, RMSK, "brake_lat");
    for (int i = 3; i <= 6; i++) push(b + i, {3'b000, BR}, RMSK, "brake_left");
    til(b + 6);

    // Brake in IDLE: both sides.
    c = cyc;
    turn_left = 1'b0;
    push(c + 1, {3'b000, BR}, RMSK, "brake_left");
    push(c + 2, {3'b000, BR}, RMSK, "brake_left");
    for (int i = 3; i <= 6; i++) push(c + i, {BR, BR}, ALL, "brake_idle");
    til(c + 6);
    brake = 1'b0;
    push(c + 7, {BR, BR}, ALL, "brake_rel_lat");
    push(c + 8, {BR, BR}, ALL, "brake_rel_lat");
    push(c + 9, 6'b000000, ALL, "brake_rel");
    push(c + 10, 6'b000000, ALL, "brake_rel");

    while (sb.size() > 0 && cyc < c + 40) @(negedge in_clock);
    @(negedge in_clock);
    while (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL %s cyc %0d: never checked (lamps=%b)", x.name, x.at, lamps);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/taillight_sequencer.md
# taillight_sequencer

Drives both rear light clusters of the sequential-taillight design: three lamps per side, left and right, with outward-stepping turn signals on the selected side and both sides stepping together for hazard. It contains its own step-rate prescaler and mode FSM, so it runs directly on the board clock. Each side steps outward from the lamp nearest the car centre, so the right side sequences in the opposite physical direction to the left. Outputs drive the DE10-Lite LEDs directly.

## Interface
Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- STEP_HZ, 4, sequence step rate in Hz.
  - DIV = CLK_HZ/STEP_HZ, integer, ≥ 2.

Ports:
- in_clock  input  1  board clock, single clock domain.
- reset_n  input  1  asynchronous, active-low reset.
- turn_left  input  1  left turn request (switch, asynchronous to in_clock).
- turn_right  input  1  right turn request (switch, asynchronous).
- hazard  input  1  hazard request (switch, asynchronous).
- brake  input  1  brake pedal (switch, asynchronous). Only used when TAILLIGHT_BRAKE_EN is defined.
- L_A, L_B, L_C  output  1 each  left lamps, inner to outer.
- R_A, R_B, R_C  output  1 each  right lamps, inner to outer.

## Operation
- Every switch input passes through a 2-flop synchronizer. All decisions below use the synchronized values.
- Mode FSM states: IDLE, LEFT, RIGHT, HAZARD. The next state is re-evaluated every cycle:
  - HAZARD if hazard=1, or if turn_left=1 and turn_right=1.
  - Otherwise LEFT if turn_left=1.
  - Otherwise RIGHT if turn_right=1.
  - Otherwise IDLE.
- Prescaler `div_cnt`, width $clog2(DIV):
  - Counts 0..DIV-1 and wraps to 0.
  - `tick` is a 1-cycle pulse when div_cnt==DIV-1.
- Step counter `step`, 2 bits:
  - Advances on tick and wraps 3→0.
  - Held at 0 in IDLE.
- Step pattern, written inner,middle,outer (A,B,C):
  - step0 = 000
  - step1 = 100
  - step2 = 110
  - step3 = 111
- Lamp drive by state:
  - LEFT: left lamps show the step pattern; right lamps are off.
  - RIGHT: mirror of LEFT.
  - HAZARD: both sides show the same pattern in lockstep.
  - IDLE: all lamps off.
- Mode change: on any state transition, div_cnt and step are cleared in the same cycle. The new mode always starts at step0 with a full DIV period before step1.
- Sequence continues indefinitely while the mode is held.

## Timing
- Reset (asynchronous assert): all six lamp outputs, state, div_cnt, step and synchronizers go to 0/IDLE immediately. Deassertion is used synchronously.
- All lamp outputs are registered. A lamp changes exactly 1 cycle after the tick or state change that causes it.
- Switch edge to state change: 3 cycles (2 synchronizer cycles + 1 FSM register).
- One step lasts exactly DIV cycles. One full sequence lasts 4·DIV cycles.
- Reset asserted mid-sequence: outputs clear at once. After release the sequence restarts from step0.
- Tick coinciding with a state change: the state change wins; step goes to 0, not +1.
- Switch glitch shorter than 1 cycle: may or may not be captured. No other requirement.

## Configuration
- Macro: TAILLIGHT_BRAKE_EN.
- Defined:
  - brake=1 forces steady-on (111) on every side that is not currently sequencing. In IDLE that is both sides; in LEFT it is the right side; in RIGHT it is the left side.
  - In HAZARD brake has no effect.
  - brake does not reset the sequence.
  - Brake latency is 3 cycles.
- Undefined: the brake port is present but ignored, and its synchronizer is not built.

## Structure
- Shared package `taillight_pkg`:
  - mode state enum (IDLE, LEFT, RIGHT, HAZARD).
  - 3-bit step-pattern constants PAT0..PAT3.
  - lamp-off / lamp-all-on constants.
- Sub-module `blink_tick_gen` (param DIV; ports in_clock, reset_n, clear, tick). Holds the prescaler. The top level drives `clear` on state change.
- Synchronizers are inline in the top level.

## Test plan
Run with CLK_HZ=8, STEP_HZ=2 (DIV=4).
- Reset held with turn_left=1 → all outputs 0. After release, L_A..L_C step 000,100,110,111,000 every 4 cycles, starting 3 cycles after release. R_* stay 0.
- turn_right=1 → R side shows the same pattern; L side stays 0. Drop turn_right at step2 → all outputs 0 within 3 cycles.
- turn_left=1 and turn_right=1 together → HAZARD; both sides show identical patterns in lockstep over 16 cycles.
- LEFT at step3, then switch to hazard=1 with the state change landing on a tick cycle → both sides 000 and stay 000 for 4 cycles, then 100.
- Assert reset_n=0 mid-step2 for 1 cycle → outputs 0 the same cycle. Sequence restarts at step0.
- TAILLIGHT_BRAKE_EN defined, turn_left=1 and brake=1 → R_A..R_C=111 steady while left sequences. In IDLE with brake=1 → all six lamps 1. Without the macro the same stimulus → R_* = 000.
